// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the multi-master bus arbiter.
package bus_arbiter_pkg;

    typedef enum logic [2:0] {
        CPU_OWNS = 3'd0,
        SYNC     = 3'd1,
        HOLD     = 3'd2,
        AEN      = 3'd3,
        MASTER   = 3'd4
    } arb_state_t;

    // Bit positions inside a 4-bit active-low command word.
    localparam int CMD_IOR  = 0;
    localparam int CMD_IOW  = 1;
    localparam int CMD_MEMR = 2;
    localparam int CMD_MEMW = 3;

endpackage

// File: rtl/bus_priority_select.sv
// Combinational winner search over the request vector, fixed or rotating from pointer+1.
module bus_priority_select #(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_WIDTH   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic [NUM_MASTERS-1:0] request,
    input  logic [IDX_WIDTH-1:0]   pointer,
    input  logic                   rotate,
    output logic [IDX_WIDTH-1:0]   index,
    output logic                   valid
);

    int slot;

    always_comb begin
        valid = 1'b0;
        index = '0;
        slot  = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            slot = rotate ? ((int'(pointer) + 1 + k) % NUM_MASTERS) : k;
            if (!valid && request[slot]) begin
                valid = 1'b1;
                index = IDX_WIDTH'(slot);
            end
        end
    end

endmodule

// File: rtl/multi_master_bus_arbiter.sv
// Takes the bus from the 8088 on a passive cycle and hands it to one requesting master,
// sequenced on cpu_clock edges sampled in the clock domain.
//
// state    | meaning
// CPU_OWNS | CPU drives the bus, waiting for a passive unlocked cycle with a request
// SYNC     | winner latched, waiting for the cpu_clock falling edge
// HOLD     | CPU held off, address enables still with the CPU
// AEN      | address_enable_n high, CPU drivers released
// MASTER   | winner acknowledged and driving address/command
module multi_master_bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS     = 4,
    parameter int ADDR_WIDTH      = 20,
    parameter int ROTATE_PRIORITY = 0,
    parameter int GRANT_LIMIT     = 0
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              cpu_clock,
    input  logic [2:0]                        processor_status,
    input  logic                              processor_lock_n,
    input  logic [ADDR_WIDTH-1:0]             cpu_address,
    input  logic [NUM_MASTERS-1:0]            master_request,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] master_address,
    input  logic [NUM_MASTERS*4-1:0]          master_command_n,
    output logic [NUM_MASTERS-1:0]            master_acknowledge_n,
    output logic                              address_enable_n,
    output logic                              dma_wait_n,
    output logic [ADDR_WIDTH-1:0]             address,
    output logic [3:0]                        command_n,
    output logic [$clog2(NUM_MASTERS):0]      bus_owner,
    output logic                              grant_overrun
);

    localparam int IDX_WIDTH   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int OWNER_WIDTH = $clog2(NUM_MASTERS) + 1;
    localparam int CNT_WIDTH   = (GRANT_LIMIT > 0) ? $clog2(GRANT_LIMIT + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(GRANT_LIMIT);

    arb_state_t             state;
    logic                   cpu_clock_q;
    logic                   pos_edge;
    logic                   neg_edge;
    logic [IDX_WIDTH-1:0]   winner;
    logic [IDX_WIDTH-1:0]   rotate_ptr;
    logic [IDX_WIDTH-1:0]   sel_index;
    logic                   sel_valid;
    logic                   winner_req;
    logic                   bus_free;
    logic [CNT_WIDTH-1:0]   wd_count;
    logic [CNT_WIDTH-1:0]   wd_next;
    logic [OWNER_WIDTH-1:0] owner_word;

    bus_priority_select #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_WIDTH   (IDX_WIDTH)
    ) u_select (
        .request (master_request),
        .pointer (rotate_ptr),
        .rotate  (ROTATE_PRIORITY != 0),
        .index   (sel_index),
        .valid   (sel_valid)
    );

    assign pos_edge   = cpu_clock & ~cpu_clock_q;
    assign neg_edge   = ~cpu_clock & cpu_clock_q;
    assign winner_req = master_request[winner];
    assign bus_free   = (processor_status == 3'b111) && processor_lock_n && sel_valid;
    assign wd_next    = wd_count + 1'b1;

    always_comb begin
        owner_word = '0;
        owner_word[OWNER_WIDTH-1] = 1'b1;
        for (int i = 0; i < OWNER_WIDTH - 1; i++) begin
            owner_word[i] = winner[i];
        end
    end

    // Mux follows the registered state so a reset drops the master off the bus at once.
    assign address   = (state == MASTER) ? master_address[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH]
                                         : cpu_address;
    assign command_n = (state == MASTER) ? master_command_n[int'(winner)*4 +: 4] : 4'b1111;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state                <= CPU_OWNS;
            cpu_clock_q          <= 1'b0;
            winner               <= '0;
            rotate_ptr           <= IDX_WIDTH'(NUM_MASTERS - 1);
            wd_count             <= '0;
            master_acknowledge_n <= '1;
            address_enable_n     <= 1'b0;
            dma_wait_n           <= 1'b1;
            bus_owner            <= '0;
            grant_overrun        <= 1'b0;
        end else begin
            cpu_clock_q <= cpu_clock;
            case (state)
                CPU_OWNS: begin
                    if (pos_edge && bus_free) begin
                        state         <= SYNC;
                        winner        <= sel_index;
                        grant_overrun <= 1'b0;
                    end
                end
                SYNC: begin
                    if (neg_edge) begin
                        state <= winner_req ? HOLD : CPU_OWNS;
                    end
                end
                HOLD: begin
                    if (pos_edge) begin
                        if (winner_req) begin
                            state            <= AEN;
                            address_enable_n <= 1'b1;
                        end else begin
                            state <= CPU_OWNS;
                        end
                    end
                end
                AEN: begin
                    if (pos_edge) begin
                        if (winner_req) begin
                            state                <= MASTER;
                            dma_wait_n           <= 1'b0;
                            master_acknowledge_n <= ~(NUM_MASTERS'(1) << winner);
                            bus_owner            <= owner_word;
                            rotate_ptr           <= winner;
                            wd_count             <= '0;
                        end else begin
                            state            <= CPU_OWNS;
                            address_enable_n <= 1'b0;
                        end
                    end
                end
                MASTER: begin
                    if (pos_edge) begin
                        if (!winner_req) begin
                            state                <= CPU_OWNS;
                            master_acknowledge_n <= '1;
                            dma_wait_n           <= 1'b1;
                            address_enable_n     <= 1'b0;
                            bus_owner            <= '0;
                        end else if (GRANT_LIMIT != 0 && wd_count != LIMIT) begin
                            // Saturates at the limit; the flag only reports, never releases.
                            wd_count <= wd_next;
                            if (wd_next == LIMIT) begin
                                grant_overrun <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= CPU_OWNS;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_master_bus_arbiter.sv
// Scoreboard bench: expected grant indices are queued as requests are driven and
// popped when an acknowledge appears.
module tb_multi_master_bus_arbiter;
    import bus_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int AW = 20;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            cpu_clock = 1'b0;
    logic [2:0]      processor_status = 3'b111;
    logic            processor_lock_n = 1'b1;
    logic [AW-1:0]   cpu_address = 20'h12345;
    logic [N-1:0]    master_request = '0;
    logic [N*AW-1:0] master_address;
    logic [N*4-1:0]  master_command_n;
    logic [N-1:0]    master_acknowledge_n;
    logic            address_enable_n;
    logic            dma_wait_n;
    logic [AW-1:0]   address;
    logic [3:0]      command_n;
    logic [2:0]      bus_owner;
    logic            grant_overrun;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];
    int idx;

    multi_master_bus_arbiter #(
        .NUM_MASTERS     (N),
        .ADDR_WIDTH      (AW),
        .ROTATE_PRIORITY (1),
        .GRANT_LIMIT     (5)
    ) dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .cpu_clock            (cpu_clock),
        .processor_status     (processor_status),
        .processor_lock_n     (processor_lock_n),
        .cpu_address          (cpu_address),
        .master_request       (master_request),
        .master_address       (master_address),
        .master_command_n     (master_command_n),
        .master_acknowledge_n (master_acknowledge_n),
        .address_enable_n     (address_enable_n),
        .dma_wait_n           (dma_wait_n),
        .address              (address),
        .command_n            (command_n),
        .bus_owner            (bus_owner),
        .grant_overrun        (grant_overrun)
    );

    always #5 clock = ~clock;

    // cpu_clock edges sit 2 ns after a clock negedge, never on a clock posedge.
    initial begin
        #2;
        forever #40 cpu_clock = ~cpu_clock;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        if (obs !== want) begin
            n_errors++;
            $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(int i);
        return 20'hA0000 + AW'(i * 'h1111);
    endfunction

    function automatic logic [3:0] cmd_of(int i);
        logic [3:0] c;
        c = 4'hF;
        case (i)
            0:       c[CMD_IOR]  = 1'b0;
            1:       c[CMD_IOW]  = 1'b0;
            2:       c[CMD_MEMR] = 1'b0;
            default: c[CMD_MEMW] = 1'b0;
        endcase
        return c;
    endfunction

    function automatic int low_idx(logic [N-1:0] a);
        for (int i = 0; i < N; i++) begin
            if (!a[i]) return i;
        end
        return -1;
    endfunction

    task automatic wait_ack(output int gidx);
        gidx = -1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clock);
            if (master_acknowledge_n != '1) begin
                gidx = low_idx(master_acknowledge_n);
                break;
            end
        end
        check_eq("grant_seen", 32'(gidx >= 0), 1);
    endtask

    // Grant/release monitor: pops the scoreboard on each new acknowledge.
    initial begin
        logic [N-1:0] prev_ack;
        logic [N-1:0] ack_exp;
        int           gi;
        int           ge;
        prev_ack = '1;
        forever begin
            @(negedge clock);
            if (reset_n && prev_ack == '1 && master_acknowledge_n != '1) begin
                gi = low_idx(master_acknowledge_n);
                check_eq("grant_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    ge = exp_q.pop_front();
                    ack_exp = ~(4'b0001 << ge);
                    check_eq("grant_idx", gi, ge);
                    check_eq("grant_ack", master_acknowledge_n, ack_exp);
                    check_eq("grant_owner", bus_owner, {1'b1, 2'(ge)});
                    check_eq("grant_addr", address, addr_of(ge));
                    check_eq("grant_cmd", command_n, cmd_of(ge));
                    check_eq("grant_dma_wait", dma_wait_n, 1'b0);
                    check_eq("grant_aen", address_enable_n, 1'b1);
                end
            end
            if (reset_n && prev_ack != '1 && master_acknowledge_n == '1) begin
                check_eq("release_cmd", command_n, 4'hF);
                check_eq("release_addr", address, cpu_address);
                check_eq("release_owner", bus_owner, 3'b000);
                check_eq("release_dma_wait", dma_wait_n, 1'b1);
                check_eq("release_aen", address_enable_n, 1'b0);
            end
            prev_ack = master_acknowledge_n;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed still_running expected finished");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            master_address[i*AW +: AW] = addr_of(i);
            master_command_n[i*4 +: 4] = cmd_of(i);
        end

        // Reset values
        #50;
        check_eq("rst_ack", master_acknowledge_n, 4'hF);
        check_eq("rst_aen", address_enable_n, 1'b0);
        check_eq("rst_dma_wait", dma_wait_n, 1'b1);
        check_eq("rst_cmd", command_n, 4'hF);
        check_eq("rst_owner", bus_owner, 3'b000);
        check_eq("rst_overrun", grant_overrun, 1'b0);
        check_eq("rst_addr", address, cpu_address);
        #50 reset_n = 1'b1;

        // Rotating: all request, each holds 3 periods -> 0,1,2,3,0
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        exp_q.push_back(3); exp_q.push_back(0);
        @(posedge cpu_clock); #12;
        master_request = '1;
        for (int g = 0; g < 5; g++) begin
            wait_ack(idx);
            if (idx < 0) break;
            repeat (3) @(posedge cpu_clock);
            #12;
            if (g == 4) master_request = '0;
            else master_request[idx] = 1'b0;
            @(posedge cpu_clock); #20;
            check_eq("cpu_slot_aen", address_enable_n, 1'b0);
            check_eq("short_hold_overrun", grant_overrun, 1'b0);
            if (g < 4) master_request[idx] = 1'b1;
        end
        repeat (2) @(posedge cpu_clock);

        // Requests 0110 -> master 1 acknowledged two cpu periods after the qualifying edge
        #12;
        exp_q.push_back(1);
        master_request = 4'b0110;
        @(posedge cpu_clock); #20;
        check_eq("lat_sync_aen", address_enable_n, 1'b0);
        @(posedge cpu_clock); #20;
        check_eq("lat_aen_up", address_enable_n, 1'b1);
        check_eq("lat_no_ack_yet", master_acknowledge_n, 4'hF);
        check_eq("lat_dma_idle", dma_wait_n, 1'b1);
        @(posedge cpu_clock); #20;
        check_eq("lat_ack", master_acknowledge_n, 4'b1101);
        check_eq("lat_owner", bus_owner, 3'b101);
        check_eq("lat_addr", address, addr_of(1));
        master_request = '0;
        @(posedge cpu_clock); #20;
        check_eq("lat_release_ack", master_acknowledge_n, 4'hF);
        check_eq("lat_release_aen", address_enable_n, 1'b0);

        // Active status and then lock both block the takeover
        @(posedge cpu_clock); #12;
        processor_status = 3'b000;
        master_request = 4'b0001;
        repeat (2) begin
            @(posedge cpu_clock); #20;
            check_eq("status_block_aen", address_enable_n, 1'b0);
        end
        processor_status = 3'b111;
        processor_lock_n = 1'b0;
        repeat (2) begin
            @(posedge cpu_clock); #20;
            check_eq("lock_block_aen", address_enable_n, 1'b0);
            check_eq("lock_block_ack", master_acknowledge_n, 4'hF);
        end
        exp_q.push_back(0);
        processor_lock_n = 1'b1;
        wait_ack(idx);
        @(posedge cpu_clock); #12;
        master_request = '0;
        @(posedge cpu_clock); #20;

        // Abort: master 2 drops exactly on the AEN->MASTER cpu posedge
        @(posedge cpu_clock); #12;
        master_request = 4'b0100;
        @(posedge cpu_clock);
        @(posedge cpu_clock); #20;
        check_eq("abort_aen_up", address_enable_n, 1'b1);
        @(posedge cpu_clock);
        master_request = '0;
        #20;
        check_eq("abort_aen_down", address_enable_n, 1'b0);
        check_eq("abort_no_ack", master_acknowledge_n, 4'hF);
        check_eq("abort_dma_wait", dma_wait_n, 1'b1);
        // Pointer still at 0 after the abort, so master 1 wins next
        exp_q.push_back(1);
        master_request = '1;
        wait_ack(idx);
        @(posedge cpu_clock); #12;
        master_request = '0;
        @(posedge cpu_clock); #20;

        // Watchdog: limit 5, master 3 holds 8 periods
        @(posedge cpu_clock); #12;
        exp_q.push_back(3);
        master_request = 4'b1000;
        wait_ack(idx);
        for (int k = 1; k <= 8; k++) begin
            @(posedge cpu_clock); #20;
            check_eq((k < 5) ? "wd_not_yet" : "wd_set", grant_overrun, 32'(k >= 5));
            if (k <= 7) check_eq("wd_no_early_release", master_acknowledge_n, 4'b0111);
            if (k == 7) master_request = '0;
        end
        check_eq("wd_released", master_acknowledge_n, 4'hF);
        exp_q.push_back(0);
        master_request = 4'b0001;
        @(posedge cpu_clock); #20;
        check_eq("wd_clear_on_sync", grant_overrun, 1'b0);
        wait_ack(idx);
        @(posedge cpu_clock); #12;
        master_request = '0;
        @(posedge cpu_clock); #20;

        // Reset in the middle of a grant
        @(posedge cpu_clock); #12;
        exp_q.push_back(2);
        master_request = 4'b0100;
        wait_ack(idx);
        @(posedge cpu_clock); #36;
        reset_n = 1'b0;
        master_request = '0;
        #1;
        check_eq("mid_rst_ack", master_acknowledge_n, 4'hF);
        check_eq("mid_rst_dma_wait", dma_wait_n, 1'b1);
        check_eq("mid_rst_cmd", command_n, 4'hF);
        check_eq("mid_rst_aen", address_enable_n, 1'b0);
        check_eq("mid_rst_owner", bus_owner, 3'b000);
        #20 reset_n = 1'b1;
        // Pointer back at NUM_MASTERS-1, so master 0 wins
        exp_q.push_back(0);
        @(posedge cpu_clock); #12;
        master_request = '1;
        wait_ack(idx);
        @(posedge cpu_clock); #12;
        master_request = '0;
        repeat (2) @(posedge cpu_clock);
        #12;

        check_eq("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multi_master_bus_arbiter.md
# multi_master_bus_arbiter

- Parametrised successor to the XT bus arbitration logic.
- Takes the system bus from the 8088 CPU and grants it to one of `NUM_MASTERS` requesting bus masters (DMA channels, later bus-mastering cards).
- Sits between the CPU/8288 path and the peripheral bus, and drives the shared address and command lines.
- Adds beyond the fixed 8237 hold path:
  - fixed or rotating priority;
  - abort on request withdrawal;
  - a grant-length watchdog.

## Interface
Parameters:
- `NUM_MASTERS`, 4, number of requesting masters (1–8)
- `ADDR_WIDTH`, 20, bus address width
- `ROTATE_PRIORITY`, 0, 0 = fixed (index 0 highest), 1 = round-robin
- `GRANT_LIMIT`, 0, watchdog limit in cpu_clock posedges while a master owns the bus; 0 disables

Ports:
- `clock` in 1: system clock; reset is asynchronous and active-low (`reset_n`)
- `reset_n` in 1: asynchronous active-low reset
- `cpu_clock` in 1: CPU clock level, sampled on `clock`
- `processor_status` in 3: 8088 S2..S0
- `processor_lock_n` in 1: CPU LOCK
- `cpu_address` in ADDR_WIDTH: CPU latched address
- `master_request` in NUM_MASTERS: per-master bus request, level
- `master_address` in NUM_MASTERS×ADDR_WIDTH: per-master address
- `master_command_n` in NUM_MASTERS×4: per-master {mem_write_n, mem_read_n, io_write_n, io_read_n}
- `master_acknowledge_n` out NUM_MASTERS: one-hot-low grant
- `address_enable_n` out 1: high while CPU is off the bus
- `dma_wait_n` out 1: low while a master owns the bus
- `address` out ADDR_WIDTH: muxed bus address
- `command_n` out 4: muxed master command, all-ones when no master owns the bus
- `bus_owner` out $clog2(NUM_MASTERS)+1: MSB=1 means a master owns the bus, low bits give its index
- `grant_overrun` out 1: sticky watchdog flag

## Operation
States: `CPU_OWNS`, `SYNC`, `HOLD`, `AEN`, `MASTER`.

cpu_clock edges:
- Detected with a registered previous value.
- All transitions happen in the `clock` cycle where the edge pulse is high.

Transitions:
- **`CPU_OWNS` → `SYNC`** at posedge when all of the following hold; the winner is latched at this point:
  - `processor_status` == 3'b111;
  - `processor_lock_n` = 1;
  - `master_request` != 0.
- **`SYNC` → `HOLD`** at the next negedge if the winner is still requesting; else → `CPU_OWNS`.
- **`HOLD` → `AEN`** at the next posedge; `address_enable_n` goes to 1.
- **`AEN` → `MASTER`** at the next posedge:
  - `dma_wait_n` goes to 0;
  - `master_acknowledge_n[winner]` goes to 0;
  - `bus_owner` = {1, winner}.
- **Abort:** in `HOLD` or `AEN`, if the winner's request is low at a posedge → `CPU_OWNS`. `address_enable_n` and `dma_wait_n` return to their idle values at that posedge.
- **Release:** in `MASTER`, if the winner's request is low at a posedge → `CPU_OWNS` in the same edge. Ack, `dma_wait_n` and `address_enable_n` all deassert together.
- **CPU slot after release:** the bus always returns to the CPU for at least one cpu_clock period before the next `SYNC`, even if other requests are pending.

Priority:
- Fixed mode: lowest index wins.
- Rotating mode: search starts at pointer+1. The pointer is updated to the winner on entry to `MASTER`; aborts do not move it. The pointer resets to NUM_MASTERS-1, so master 0 wins first.
- The winner does not change after latching; new requests are ignored until `CPU_OWNS`.

Muxing:
- `address` = `master_address[winner]` in `MASTER`, else `cpu_address`.
- `command_n` = `master_command_n[winner]` in `MASTER`, else 4'b1111.

Watchdog:
- Counter clears on `MASTER` entry and increments per posedge while in `MASTER`.
- When count reaches `GRANT_LIMIT`, `grant_overrun` sets. It stays set through release and is cleared on the next `SYNC` entry.
- The watchdog never forces release.

## Timing
Reset values (async):
- state `CPU_OWNS`;
- `address_enable_n` = 0, `dma_wait_n` = 1;
- `master_acknowledge_n` all 1s, `command_n` = 4'b1111;
- `bus_owner` = 0, `grant_overrun` = 0;
- rotate pointer NUM_MASTERS-1, watchdog count 0.

Grant latency and visibility:
- Best-case grant latency from the qualifying posedge: 2 posedges + 1 negedge, i.e. `master_acknowledge_n` low 2 cpu_clock periods later.
- Outputs are registered and visible one `clock` after the edge-detect cycle.
- `address` and `command_n` are combinational from the registered state and winner.

Boundary conditions:
- Request drops exactly on the `AEN` → `MASTER` posedge → abort wins and there is no acknowledge.
- Reset mid-`MASTER` → all outputs take reset values immediately; the master sees its acknowledge drop asynchronously.
- `NUM_MASTERS` = 1 → rotating mode is equivalent to fixed mode.

## Structure
- Package `bus_arbiter_pkg`:
  - state enum `arb_state_t`;
  - command bit index constants (`CMD_IOR`, `CMD_IOW`, `CMD_MEMR`, `CMD_MEMW`).
- Sub-module `bus_priority_select`: parametrised request vector + pointer + mode → winner index + valid (combinational).
- All sequencing stays in the top module.

## Test plan
- Fixed priority: requests 4'b0110 with status 3'b111 → master 1 acknowledged after 2 cpu_clock periods; `address` = `master_address[1]`, `bus_owner` = 3'b101.
- Rotating: all four requesting continuously, each releasing after 3 periods → grant order 0, 1, 2, 3, 0, with one CPU period between grants.
- Lock: `processor_lock_n` = 0 with status 3'b111 and a request present → no `SYNC` entry and `address_enable_n` stays 0; lock released → grant proceeds.
- Abort: master 2 drops its request while in `AEN` → `address_enable_n` back to 0 at the next posedge, no acknowledge pulse, rotate pointer unchanged.
- Watchdog: `GRANT_LIMIT` = 5, master holds for 8 periods → `grant_overrun` sets on the 5th posedge, bus not released early, flag clears on the next `SYNC`.
- Reset: assert `reset_n` = 0 in `MASTER` → `master_acknowledge_n` = all 1s, `dma_wait_n` = 1, `command_n` = 4'b1111 without waiting for a clock edge.
